// File: rtl/ex_stage_control.sv
// rtl/ex_stage_control.sv - execute-stage control: IR3/IR4, decode, forwarding, flags, branch, stop FSM
module ex_stage_control #(
  parameter int IW  = 8,
  parameter int OPW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ir3_load,
  input  logic [IW-1:0] ir2_in,
  input  logic          alu_z,
  input  logic          alu_n,
  output logic [IW-1:0] ir3_out,
  output logic [IW-1:0] ir4_out,
  output logic [2:0]    alu_op,
  output logic          alu_src_imm,
  output logic          fwd_a,
  output logic          fwd_b,
  output logic          mem_read,
  output logic          mem_write,
  output logic          branch_taken,
  output logic          flush,
  output logic          halted
);

  localparam logic [IW-1:0] BUBBLE = IW'(8'h0A);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ir3_q, ir3_d;
  logic [IW-1:0]   ir4_q, ir4_d;
  logic            z_q, z_d;
  logic            n_q, n_d;

  logic [OPW-1:0]  op3;
  logic            is_ori, is_shift, is_load, is_store, is_add, is_sub, is_nand;
  logic            is_bz, is_bnz, is_bpz, is_stop;
  logic            reads_a, reads_b, sets_flags;

  // True when the instruction writes a register (ORI and shift are matched on their 3-bit code first)
  function automatic logic writes_reg(input logic [IW-1:0] ir);
    logic w;
    w = 1'b0;
    if (ir[2:0] == 3'b111 || ir[2:0] == 3'b011) begin
      w = 1'b1;
    end else begin
      case (ir[3:0])
        4'b0000, 4'b0100, 4'b0110, 4'b1000: w = 1'b1;
        default:                            w = 1'b0;
      endcase
    end
    return w;
  endfunction

  // Register named by the A field; ORI implicitly uses r1 for both dest and source
  function automatic logic [1:0] reg_a(input logic [IW-1:0] ir);
    return (ir[2:0] == 3'b111) ? 2'b01 : ir[7:6];
  endfunction

  assign op3 = ir3_q[OPW-1:0];

  // Decode IR3 into one-hot instruction classes
  always_comb begin
    is_ori   = (op3[2:0] == 3'b111);
    is_shift = (op3[2:0] == 3'b011);
    is_load  = (op3 == 4'b0000);
    is_store = (op3 == 4'b0010);
    is_add   = (op3 == 4'b0100);
    is_sub   = (op3 == 4'b0110);
    is_nand  = (op3 == 4'b1000);
    is_bz    = (op3 == 4'b0101);
    is_bnz   = (op3 == 4'b1001);
    is_bpz   = (op3 == 4'b1101);
    is_stop  = (op3 == 4'b0001);
  end

  assign reads_a    = is_load | is_store | is_add | is_sub | is_nand | is_ori | is_shift;
  assign reads_b    = is_load | is_store | is_add | is_sub | is_nand;
  assign sets_flags = is_add | is_sub | is_nand | is_ori | is_shift;

  assign halted = (state_q == ST_HALTED);

  // ALU operation select and combinational datapath controls
  always_comb begin
    alu_op = 3'b000;
    if (is_sub)                alu_op = 3'b001;
    else if (is_nand)          alu_op = 3'b010;
    else if (is_ori)           alu_op = 3'b011;
    else if (is_shift)         alu_op = 3'b100;
    else if (is_load | is_store) alu_op = 3'b101;
    alu_src_imm  = (is_ori | is_shift) & ~halted;
    mem_read     = is_load & ~halted;
    mem_write    = is_store & ~halted;
    branch_taken = (is_bz & z_q) | (is_bnz & ~z_q) | (is_bpz & ~n_q);
    fwd_a        = writes_reg(ir4_q) && (reg_a(ir4_q) == reg_a(ir3_q)) && reads_a;
    fwd_b        = writes_reg(ir4_q) && (reg_a(ir4_q) == ir3_q[5:4]) && reads_b;
  end

  assign flush   = branch_taken;
  assign ir3_out = ir3_q;
  assign ir4_out = ir4_q;

  // Next-state: stop FSM, instruction registers and flags
  always_comb begin
    state_d = state_q;
    ir3_d   = BUBBLE;
    ir4_d   = ir3_q;
    z_d     = z_q;
    n_d     = n_q;
    case (state_q)
      ST_RUN:    if (is_stop) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_HALTED;
      default:   state_d = ST_HALTED;
    endcase
    if (state_q != ST_RUN)  ir3_d = ir3_q;
    else if (branch_taken)  ir3_d = BUBBLE;
    else if (ir3_load)      ir3_d = ir2_in;
    if (state_q == ST_HALTED) ir4_d = BUBBLE;
    if (sets_flags && state_q != ST_HALTED) begin
      z_d = alu_z;
      n_d = alu_n;
    end
  end

  // State register with synchronous reset to an empty running pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      ir3_q   <= BUBBLE;
      ir4_q   <= BUBBLE;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir3_q   <= ir3_d;
      ir4_q   <= ir4_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

endmodule

// File: tb/tb_ex_stage_control.sv
// tb/tb_ex_stage_control.sv - self-checking bench for ex_stage_control
module tb_ex_stage_control;

  logic       clock = 1'b0;
  logic       reset, ir3_load, alu_z, alu_n;
  logic [7:0] ir2_in;
  logic [7:0] ir3_out, ir4_out;
  logic [2:0] alu_op;
  logic       alu_src_imm, fwd_a, fwd_b, mem_read, mem_write, branch_taken, flush, halted;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ex_stage_control #(.IW(8), .OPW(4)) dut (
    .clock(clock), .reset(reset), .ir3_load(ir3_load), .ir2_in(ir2_in),
    .alu_z(alu_z), .alu_n(alu_n), .ir3_out(ir3_out), .ir4_out(ir4_out),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_read(mem_read), .mem_write(mem_write), .branch_taken(branch_taken),
    .flush(flush), .halted(halted)
  );

  localparam int K_NOP = 0, K_LOAD = 1, K_STORE = 2, K_ADD = 3, K_SUB = 4, K_NAND = 5;
  localparam int K_ORI = 6, K_SHIFT = 7, K_BZ = 8, K_BNZ = 9, K_BPZ = 10, K_STOP = 11;

  function automatic int kind(input logic [7:0] ir);
    if (ir[2:0] == 3'b111) return K_ORI;
    if (ir[2:0] == 3'b011) return K_SHIFT;
    case (ir[3:0])
      4'h0: return K_LOAD;
      4'h2: return K_STORE;
      4'h4: return K_ADD;
      4'h6: return K_SUB;
      4'h8: return K_NAND;
      4'h5: return K_BZ;
      4'h9: return K_BNZ;
      4'hD: return K_BPZ;
      4'h1: return K_STOP;
      default: return K_NOP;
    endcase
  endfunction

  function automatic bit writes(input int k);
    return k inside {K_LOAD, K_ADD, K_SUB, K_NAND, K_ORI, K_SHIFT};
  endfunction
  function automatic bit reads_a(input int k);
    return k inside {K_LOAD, K_STORE, K_ADD, K_SUB, K_NAND, K_ORI, K_SHIFT};
  endfunction
  function automatic bit reads_b(input int k);
    return k inside {K_LOAD, K_STORE, K_ADD, K_SUB, K_NAND};
  endfunction
  function automatic logic [1:0] field_a(input logic [7:0] ir);
    return (kind(ir) == K_ORI) ? 2'd1 : ir[7:6];
  endfunction
  function automatic logic [2:0] op_of(input int k);
    case (k)
      K_SUB: return 3'd1;
      K_NAND: return 3'd2;
      K_ORI: return 3'd3;
      K_SHIFT: return 3'd4;
      K_LOAD, K_STORE: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Reference state: st 0 = running, 1 = draining, 2 = halted
  logic [7:0] m_ir3 = 8'h0A, m_ir4 = 8'h0A;
  bit m_z = 0, m_n = 0, m_valid = 0;
  int m_st = 0;

  function automatic bit m_branch();
    int k;
    k = kind(m_ir3);
    return (k == K_BZ && m_z) || (k == K_BNZ && !m_z) || (k == K_BPZ && !m_n);
  endfunction

  function automatic logic [26:0] expected();
    int k3, k4;
    bit h, br;
    k3 = kind(m_ir3);
    k4 = kind(m_ir4);
    h  = (m_st == 2);
    br = m_branch();
    return {m_ir3, m_ir4, op_of(k3),
            !h && (k3 == K_ORI || k3 == K_SHIFT),
            writes(k4) && field_a(m_ir4) == field_a(m_ir3) && reads_a(k3),
            writes(k4) && field_a(m_ir4) == m_ir3[5:4] && reads_b(k3),
            !h && k3 == K_LOAD, !h && k3 == K_STORE, br, br, h};
  endfunction

  function automatic logic [26:0] observed();
    return {ir3_out, ir4_out, alu_op, alu_src_imm, fwd_a, fwd_b,
            mem_read, mem_write, branch_taken, flush, halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare all outputs against the model, advance both
  task automatic cyc(input logic r, input logic ld, input logic [7:0] d, input logic z, input logic n);
    logic [7:0] n_ir3, n_ir4;
    bit n_z, n_n;
    int n_st, k3;
    reset = r; ir3_load = ld; ir2_in = d; alu_z = z; alu_n = n;
    #1;
    if (m_valid) check("outs", {5'd0, observed()}, {5'd0, expected()});
    if (r) begin
      n_ir3 = 8'h0A; n_ir4 = 8'h0A; n_z = 0; n_n = 0; n_st = 0;
    end else begin
      k3 = kind(m_ir3);
      if (m_st != 0)      n_ir3 = m_ir3;
      else if (m_branch()) n_ir3 = 8'h0A;
      else if (ld)        n_ir3 = d;
      else                n_ir3 = 8'h0A;
      n_ir4 = (m_st == 2) ? 8'h0A : m_ir3;
      n_z = m_z; n_n = m_n;
      if (k3 inside {K_ADD, K_SUB, K_NAND, K_ORI, K_SHIFT} && m_st != 2) begin
        n_z = z; n_n = n;
      end
      if (m_st == 0) n_st = (k3 == K_STOP) ? 1 : 0;
      else           n_st = 2;
    end
    @(posedge clock);
    m_ir3 = n_ir3; m_ir4 = n_ir4; m_z = n_z; m_n = n_n; m_st = n_st;
    if (r) m_valid = 1;
    @(negedge clock);
  endtask

  initial begin
    reset = 1; ir3_load = 0; ir2_in = 8'h00; alu_z = 0; alu_n = 0;
    @(negedge clock);
    cyc(1, 0, 8'h00, 0, 0);
    check("rst_ir3", ir3_out, 8'h0A);
    check("rst_ir4", ir4_out, 8'h0A);
    check("rst_ctl", {alu_op, alu_src_imm, fwd_a, fwd_b, mem_read, mem_write,
                      branch_taken, flush, halted}, 0);

    cyc(0, 1, 8'h54, 0, 0);
    check("add_ir3", ir3_out, 8'h54);
    check("add_op", alu_op, 3'b000);
    check("add_fwd_a", fwd_a, 1'b0);
    cyc(0, 1, 8'h66, 0, 0);
    check("add_ir4", ir4_out, 8'h54);
    check("sub_fwd", {fwd_a, fwd_b}, 2'b10);
    check("sub_op", alu_op, 3'b001);

    cyc(0, 1, 8'h40, 0, 0);
    cyc(0, 1, 8'h1F, 0, 0);
    check("ori_fwd_a", fwd_a, 1'b1);
    check("ori_imm", alu_src_imm, 1'b1);
    check("ori_op", alu_op, 3'b011);

    cyc(0, 1, 8'h66, 0, 0);
    cyc(0, 1, 8'h05, 1, 0);
    check("bz_taken", {branch_taken, flush}, 2'b11);
    cyc(0, 1, 8'h54, 0, 0);
    check("bz_bubble", ir3_out, 8'h0A);
    cyc(0, 1, 8'h66, 0, 0);
    cyc(0, 1, 8'h05, 0, 0);
    check("bz_not", {branch_taken, flush}, 2'b00);
    cyc(0, 1, 8'h54, 0, 0);
    check("bz_fall", ir3_out, 8'h54);

    cyc(0, 1, 8'h01, 0, 0);
    check("stop_run", halted, 1'b0);
    cyc(0, 1, 8'h22, 0, 0);
    check("drain", {halted, mem_write}, 2'b01);
    cyc(0, 1, 8'h22, 0, 0);
    check("halt", halted, 1'b1);
    cyc(0, 1, 8'h54, 0, 0);
    check("halt_ir3", ir3_out, 8'h22);
    check("halt_mw", mem_write, 1'b0);
    check("halt_ir4", ir4_out, 8'h0A);
    cyc(1, 0, 8'h00, 0, 0);
    check("unhalt", halted, 1'b0);
    check("unhalt_ir3", ir3_out, 8'h0A);

    cyc(0, 1, 8'h54, 0, 0);
    cyc(0, 1, 8'h01, 1, 1);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(1, 1, 8'h0D, 0, 0);
    check("drain_rst", halted, 1'b0);
    cyc(0, 1, 8'h0D, 0, 0);
    check("no_halt", halted, 1'b0);
    check("bpz_n0", branch_taken, 1'b1);

    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 24) == 0) || (m_st == 2 && $urandom_range(0, 3) == 0),
          $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
